adder_share_arbiter: RTL and testbench



---
 rtl/adder_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one 32-bit carry-select adder among NREQ requesters.
// Define ADDER_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin.
module adder_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_sum,
    output logic                 resp_cout,
    input  logic                 resp_ready
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0]    res_sum_q, res_sum_d;
    logic           res_cout_q, res_cout_d;

    logic           found;
    logic [IDW-1:0] win;
    logic           allow;
    logic           grant;
    logic [IDW-1:0] next_ptr;
    logic [31:0]    sel_a, sel_b;
    int             best;

    logic [31:0]    add_sum;
    logic           add_cout;
    logic [4:0]     blk_c;

    // Circular distance from the search start within a window of span requesters.
    function automatic int rr_dist(input int idx, input int start, input int span);
        return (idx - start + span) % span;
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        best  = int'(NREQ);
`ifdef ADDER_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i < int'(NREQ); i++) begin
                if (req_valid[i] &&
                    rr_dist(i, (rr_ptr_q == '0) ? 1 : int'(rr_ptr_q), int'(NREQ) - 1) < best) begin
                    best  = rr_dist(i, (rr_ptr_q == '0) ? 1 : int'(rr_ptr_q), int'(NREQ) - 1);
                    win   = IDW'(i);
                    found = 1'b1;
                end
            end
        end
`else
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req_valid[i] && rr_dist(i, int'(rr_ptr_q), int'(NREQ)) < best) begin
                best  = rr_dist(i, int'(rr_ptr_q), int'(NREQ));
                win   = IDW'(i);
                found = 1'b1;
            end
        end
`endif
    end

    // Grants are only offered when the adder is free or being freed this cycle.
    assign allow = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
    assign grant = found && allow && !rst;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = grant && (win == IDW'(i));
            if (win == IDW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

`ifdef ADDER_ARB_PRIO0_EN
    always_comb begin
        next_ptr = rr_ptr_q;
        if (win != '0) begin
            next_ptr = (win == IDW'(NREQ - 1)) ? IDW'(1) : win + 1'b1;
        end
    end
`else
    assign next_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif

    // Shared adder: 8-bit blocks precompute both carry-in cases, then select.
    assign blk_c[0] = 1'b0;
    for (genvar k = 0; k < 4; k++) begin : g_csel
        logic [8:0] s0, s1;
        assign s0 = {1'b0, op_a_q[8*k +: 8]} + {1'b0, op_b_q[8*k +: 8]};
        assign s1 = {1'b0, op_a_q[8*k +: 8]} + {1'b0, op_b_q[8*k +: 8]} + 9'd1;
        assign {blk_c[k+1], add_sum[8*k +: 8]} = blk_c[k] ? s1 : s0;
    end
    assign add_cout = blk_c[4];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        unique case (state_q)
            StIdle: if (grant) state_d = StExec;
            StExec: begin
                state_d    = StResp;
                res_sum_d  = add_sum;
                res_cout_d = add_cout;
            end
            StResp: if (resp_ready) state_d = grant ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
        if (grant) begin
            op_a_d   = sel_a;
            op_b_d   = sel_b;
            id_d     = win;
            rr_ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_id    = id_q;
    assign resp_sum   = res_sum_q;
    assign resp_cout  = res_cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: a cycle model predicts grants and results,
// directed phases cover single add, carry, fairness, backpressure, reset and withdrawal.
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_sum;
    logic                resp_cout;
    logic                resp_ready = 1'b0;

    adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cout;
        logic [31:0]    sum;
    } resp_t;

    resp_t exp_q[$];
    int    grant_log[$];
    int    grant_cyc[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    m_state  = 0;
    int    m_ptr    = 0;
    int    cycle    = 0;
    bit    mon_en   = 0;
    bit    watch_id1 = 0;
    bit    saw_id1   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
`ifdef ADDER_ARB_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            int idx;
            idx = 1 + (((ptr == 0 ? 1 : ptr) - 1 + k) % (NREQ - 1));
            if (v[idx]) return idx;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Cycle model and scoreboard, evaluated mid-cycle when inputs and outputs are settled.
    always @(negedge clk) begin
        int              w;
        bit              allow;
        bit              acc;
        logic [NREQ-1:0] exp_rdy;
        logic [32:0]     s;
        resp_t           r;
        cycle++;
        if (mon_en) begin
            allow = !rst && (m_state == 0 || (m_state == 2 && resp_ready));
            w = model_winner(req_valid, m_ptr);
            acc = allow && (w >= 0);
            exp_rdy = '0;
            if (acc) exp_rdy[w] = 1'b1;
            check_eq("req_ready", req_ready, exp_rdy);
            check_eq("resp_valid", resp_valid, m_state == 2);
            if (m_state == 2) begin
                check_eq("resp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    r = exp_q[0];
                    check_eq("resp_id", resp_id, r.id);
                    check_eq("resp_sum", resp_sum, r.sum);
                    check_eq("resp_cout", resp_cout, r.cout);
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
            if (watch_id1 && resp_valid && resp_id == 3'd1) saw_id1 = 1;
            if (!rst && |(req_ready & req_valid)) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        grant_log.push_back(i);
                        grant_cyc.push_back(cycle);
                    end
                end
            end
            if (rst) begin
                m_state = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else begin
                if (acc) begin
                    s = {1'b0, req_a[32*w +: 32]} + {1'b0, req_b[32*w +: 32]};
                    r.id   = IDW'(w);
                    r.sum  = s[31:0];
                    r.cout = s[32];
                    exp_q.push_back(r);
`ifdef ADDER_ARB_PRIO0_EN
                    if (w != 0) m_ptr = (w == NREQ - 1) ? 1 : w + 1;
`else
                    m_ptr = (w + 1) % NREQ;
`endif
                end
                case (m_state)
                    0: if (acc) m_state = 1;
                    1: m_state = 2;
                    default: if (resp_ready) m_state = acc ? 1 : 0;
                endcase
            end
        end
    end

    initial begin
        int exp_order[5];
`ifdef ADDER_ARB_PRIO0_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        // Reset with every requester asserting: nothing may be granted.
        rst = 1'b1;
        req_valid = '1;
        step();
        mon_en = 1;
        step();
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_sum", resp_sum, 0);
        check_eq("rst_id", resp_id, 0);
        check_eq("rst_cout", resp_cout, 0);
        req_valid = '0;
        rst = 1'b0;
        resp_ready = 1'b1;
        step();

        // Single request from requester 1.
        req_valid = 4'b0010;
        set_req(1, 32'h0000_0005, 32'h0000_0007);
        #1;
        check_eq("single_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        step();
        check_eq("single_valid", resp_valid, 1);
        check_eq("single_id", resp_id, 1);
        check_eq("single_sum", resp_sum, 32'h0000_000C);
        check_eq("single_cout", resp_cout, 0);
        step();

        // Carry out of bit 31 from requester 3.
        req_valid = 4'b1000;
        set_req(3, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        req_valid = '0;
        step();
        check_eq("carry_id", resp_id, 3);
        check_eq("carry_sum", resp_sum, 0);
        check_eq("carry_cout", resp_cout, 1);
        step();

        // Fairness with everyone requesting and the consumer always ready.
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_log.delete();
        grant_cyc.delete();
        req_valid = '1;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
            step();
        end
        req_valid = '0;
        check_eq("fair_count", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check_eq($sformatf("fair_order%0d", i), grant_log[i], exp_order[i]);
            if (i > 0) check_eq($sformatf("fair_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 2);
        end
        step();
        step();
        step();

        // Backpressure: response held while requester 2 waits.
        resp_ready = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 32'h8000_0000, 32'h8000_0001);
        step();
        step();
        for (int n = 0; n < 5; n++) begin
            check_eq("bp_valid", resp_valid, 1);
            check_eq("bp_sum", resp_sum, 32'h0000_0001);
            check_eq("bp_cout", resp_cout, 1);
            check_eq("bp_ready", req_ready, 0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_b2b", req_ready, 4'b0100);
        step();
        req_valid = '0;
        resp_ready = 1'b0;
        step();

        // Reset while a response is pending; requesters 0 and 1 already waiting.
        check_eq("rr_pre_valid", resp_valid, 1);
        req_valid = 4'b0011;
        set_req(0, 32'h0000_1000, 32'h0000_0234);
        set_req(1, 32'h1111_1111, 32'h2222_2222);
        resp_ready = 1'b1;
        rst = 1'b1;
        step();
        check_eq("rr_valid", resp_valid, 0);
        check_eq("rr_sum", resp_sum, 0);
        check_eq("rr_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("rr_grant0", req_ready, 4'b0001);

        // Requester 1 withdraws while requester 0 holds the grant.
        watch_id1 = 1;
        step();
        req_valid = '0;
        for (int n = 0; n < 6; n++) step();
        check_eq("withdrawn_id1", saw_id1, 0);
        watch_id1 = 0;

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        check_eq("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
